// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI slave serial engine with one-entry tx buffer
// Synchronises SCK/SS/MOSI into pclk, shifts one WIDTH-bit frame per SS window slot.
module spi_slave_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsbfe,
  input  logic             sclkin,
  input  logic             ssin,
  input  logic             mosi,
  output logic             miso,
  output logic             misooe,
  input  logic [WIDTH-1:0] txdata,
  input  logic             txload,
  output logic             txempty,
  output logic             txunderrun,
  output logic [WIDTH-1:0] rxdata,
  output logic             rxvalid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             skip_q, skip_d;
  logic [WIDTH-1:0] txbuf_q, txbuf_d;
  logic             txempty_q, txempty_d;
  logic [WIDTH-1:0] rxdata_q, rxdata_d;
  logic             rxvalid_q, rxvalid_d;
  logic             txunderrun_q, txunderrun_d;

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
  logic frame_load;
  logic [WIDTH-1:0] rx_next;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= sclkin;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      ss_s1_q   <= ssin;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sck_rise    = sck_s2_q & ~sck_s3_q;
  assign sck_fall    = ~sck_s2_q & sck_s3_q;
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_s2_q & ss_s3_q;

  always_comb begin
    state_d      = state_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    cnt_d        = cnt_q;
    skip_d       = skip_q;
    txbuf_d      = txbuf_q;
    txempty_d    = txempty_q;
    rxdata_d     = rxdata_q;
    rxvalid_d    = 1'b0;
    txunderrun_d = 1'b0;
    frame_load   = 1'b0;
    rx_next      = lsbfe ? {mosi_s2_q, rx_sr_q[WIDTH-1:1]} : {rx_sr_q[WIDTH-2:0], mosi_s2_q};

    if (txload && txempty_q) begin
      txbuf_d   = txdata;
      txempty_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          frame_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          tx_sr_d = '0;
          rx_sr_d = '0;
        end else if (sample_edge) begin
          rx_sr_d = rx_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            rxdata_d   = rx_next;
            rxvalid_d  = 1'b1;
            frame_load = 1'b1;
          end
        end else if (shift_edge) begin
          // With cpha=1 the first bit is already on MISO, so the first shift edge only arms shifting
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_sr_d = lsbfe ? {1'b0, tx_sr_q[WIDTH-1:1]} : {tx_sr_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load sees the pre-cycle buffer state, so a coincident txload still counts as an underrun
    if (frame_load) begin
      cnt_d        = '0;
      skip_d       = cpha;
      txunderrun_d = txempty_q;
      if (txempty_q) begin
        tx_sr_d = '0;
      end else begin
        tx_sr_d   = txbuf_q;
        txempty_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      cnt_q        <= '0;
      skip_q       <= 1'b0;
      txbuf_q      <= '0;
      txempty_q    <= 1'b1;
      rxdata_q     <= '0;
      rxvalid_q    <= 1'b0;
      txunderrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      cnt_q        <= cnt_d;
      skip_q       <= skip_d;
      txbuf_q      <= txbuf_d;
      txempty_q    <= txempty_d;
      rxdata_q     <= rxdata_d;
      rxvalid_q    <= rxvalid_d;
      txunderrun_q <= txunderrun_d;
    end
  end

  assign busy       = (state_q == ACTIVE);
  assign misooe     = busy;
  assign miso       = lsbfe ? tx_sr_q[0] : tx_sr_q[WIDTH-1];
  assign txempty    = txempty_q;
  assign txunderrun = txunderrun_q;
  assign rxdata     = rxdata_q;
  assign rxvalid    = rxvalid_q;

endmodule
